// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator operand-entry path.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_OP  = 2'd1,
    S_B   = 2'd2,
    S_RES = 2'd3
  } state_e;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_SUB       = 4'hB;
  localparam logic [3:0] KEY_MUL       = 4'hC;
  localparam logic [3:0] KEY_DIV       = 4'hD;
  localparam logic [3:0] KEY_EQ        = 4'hE;
  localparam logic [3:0] KEY_CLR       = 4'hF;

  // Operator keys are contiguous, so the offset from KEY_ADD is the opcode.
  function automatic opcode_e key_to_op(input logic [3:0] key);
    logic [3:0] diff;
    diff = key - KEY_ADD;
    return opcode_e'(diff[1:0]);
  endfunction

endpackage

// File: rtl/detector_tecla.sv
// Rising-edge detector on the keypad ready level; one event per key press.
module detector_tecla (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic [3:0] tecla,
  output logic       evt,
  output logic [3:0] evt_key
);

  logic r1_q, r2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= 1'b0;
      r2_q <= 1'b0;
    end else begin
      r1_q <= ready;
      r2_q <= r1_q;
    end
  end

  // The keypad controller has already registered tecla by the event cycle.
  assign evt     = r1_q & ~r2_q;
  assign evt_key = tecla;

endmodule

// File: rtl/entrada_operandos.sv
// Key-event FSM: accumulates decimal operands, captures the operator and
// offers an operand/operator bundle to the arithmetic stage.
module entrada_operandos
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OPW        = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     tecla,
  input  logic           ready,
  output logic [OPW-1:0] op_a,
  output logic [OPW-1:0] op_b,
  output logic [1:0]     opcode,
  output logic           calc_valid,
  input  logic           calc_ready,
  output logic [OPW-1:0] disp_value,
  output logic           disp_sel
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic       evt;
  logic [3:0] evt_key;

  detector_tecla u_detector (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (ready),
    .tecla   (tecla),
    .evt     (evt),
    .evt_key (evt_key)
  );

  state_e         state_q, state_d;
  logic [OPW-1:0] op_a_q, op_a_d;
  logic [OPW-1:0] op_b_q, op_b_d;
  opcode_e        opcode_q, opcode_d;
  logic           calc_valid_q, calc_valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic           is_digit, is_op, cnt_full;
  logic [OPW-1:0] digit, acc_a, acc_b;

  assign is_digit = (evt_key <= KEY_MAX_DIGIT);
  assign is_op    = (evt_key >= KEY_ADD) && (evt_key <= KEY_DIV);
  assign cnt_full = (cnt_q >= CntW'(MAX_DIGITS));
  assign digit    = OPW'(evt_key);
  assign acc_a    = (op_a_q << 3) + (op_a_q << 1) + digit;
  assign acc_b    = (op_b_q << 3) + (op_b_q << 1) + digit;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    opcode_d     = opcode_q;
    calc_valid_d = calc_valid_q;
    cnt_d        = cnt_q;

    if (evt && (evt_key == KEY_CLR)) begin
      // Clear takes precedence over a handshake in the same cycle.
      state_d      = S_A;
      op_a_d       = '0;
      op_b_d       = '0;
      opcode_d     = OP_ADD;
      calc_valid_d = 1'b0;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (evt && is_digit && !cnt_full) begin
            op_a_d = acc_a;
            cnt_d  = cnt_q + CntW'(1);
          end else if (evt && is_op) begin
            opcode_d = key_to_op(evt_key);
            state_d  = S_OP;
          end
        end
        S_OP: begin
          if (evt && is_op) begin
            opcode_d = key_to_op(evt_key);
          end else if (evt && is_digit) begin
            op_b_d  = digit;
            cnt_d   = CntW'(1);
            state_d = S_B;
          end
        end
        S_B: begin
          if (evt && is_digit && !cnt_full) begin
            op_b_d = acc_b;
            cnt_d  = cnt_q + CntW'(1);
          end else if (evt && (evt_key == KEY_EQ)) begin
            calc_valid_d = 1'b1;
            state_d      = S_RES;
          end
        end
        S_RES: begin
          // Bundle is frozen until accepted; key events are ignored here.
          if (calc_valid_q && calc_ready) begin
            calc_valid_d = 1'b0;
            op_a_d       = '0;
            op_b_d       = '0;
            cnt_d        = '0;
            state_d      = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opcode_q     <= OP_ADD;
      calc_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      opcode_q     <= opcode_d;
      calc_valid_q <= calc_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign opcode     = opcode_q;
  assign calc_valid = calc_valid_q;
  assign disp_sel   = (state_q == S_B) || (state_q == S_RES);
  assign disp_value = disp_sel ? op_b_q : op_a_q;

endmodule
